// File: rtl/ex_muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_muldiv_iter                                               |
// | Description : Iterative RISC-V M-extension unit for the EX stage.          |
// |               Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU behind a    |
// |               valid/ready request and response handshake. The multiplier  |
// |               retires MUL_STEP bits per cycle; the divider is restoring   |
// |               radix-2. Divide-by-zero and signed overflow are resolved    |
// |               without iterating.                                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   XLEN      operand/result width (even, >= 8)                              |
// |   MUL_STEP  multiplier bits retired per cycle (must divide XLEN)           |
// | Configuration macro                                                        |
// |   MULDIV_EARLY_OUT_EN  divider skips leading zeros of |dividend| and       |
// |                        returns at once when |dividend| < |divisor|.        |
// |                        Results are identical with or without it.           |
// | Ports                                                                      |
// |   clk            in   1     clock                                          |
// |   rst_n          in   1     asynchronous active-low reset                  |
// |   i_req_valid    in   1     request valid                                  |
// |   o_req_ready    out  1     unit idle and able to accept (0 during flush)  |
// |   i_req_op       in   3     funct3 of the M instruction                    |
// |   i_req_op1      in   XLEN  rs1 (multiplicand / dividend)                  |
// |   i_req_op2      in   XLEN  rs2 (multiplier / divisor)                     |
// |   i_flush        in   1     kill the operation in flight                   |
// |   i_hold         in   1     pipeline stall, freezes the iteration          |
// |   o_rsp_valid    out  1     result valid                                   |
// |   i_rsp_ready    in   1     consumer takes the result                      |
// |   o_rsp_result   out  XLEN  result                                         |
// |   o_busy         out  1     an operation is in progress                    |
// +----------------------------------------------------------------------------+
module ex_muldiv_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [2:0]      i_req_op,
  input  logic [XLEN-1:0] i_req_op1,
  input  logic [XLEN-1:0] i_req_op2,
  input  logic            i_flush,
  input  logic            i_hold,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_result,
  output logic            o_busy
);

  localparam int                 c_CNT_W    = $clog2(XLEN + 1);
  localparam logic [c_CNT_W-1:0] c_MUL_ITER = c_CNT_W'(XLEN / MUL_STEP);
  localparam logic [c_CNT_W-1:0] c_DIV_ITER = c_CNT_W'(XLEN);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [XLEN-1:0]    c_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_MUL   = 3'd2,
    S_DIV   = 3'd3,
    S_FIXUP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic                r_neg;        // final result must be negated
  logic                r_special;    // result was resolved in PREP
  logic [XLEN-1:0]     r_spec_res;
  logic [c_CNT_W-1:0]  r_cnt;        // iterations still to run
  logic [2*XLEN-1:0]   r_acc;        // product accumulator
  logic [2*XLEN-1:0]   r_mcand;      // multiplicand, pre-aligned to the digit weight
  logic [XLEN-1:0]     r_mplier;     // remaining multiplier digits, LSB first
  logic [XLEN-1:0]     r_rem;        // partial remainder
  logic [XLEN-1:0]     r_quo;        // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0]     r_dvsr;
  logic                r_rsp_valid;
  logic [XLEN-1:0]     r_rsp_result;

  // ---------------------------------------------------------------------------
  // Operand preparation (evaluated in PREP from the latched request)
  // ---------------------------------------------------------------------------
  logic                w_is_rem;
  logic                w_div_signed;
  logic                w_s1;
  logic                w_s2;
  logic                w_res_neg;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic                w_small;
  logic                w_special;
  logic [XLEN-1:0]     w_spec_res;
  logic [c_CNT_W-1:0]  w_div_iter;
  logic [XLEN-1:0]     w_dividend;

  assign w_is_rem     = r_op[2] & r_op[1];
  assign w_div_signed = r_op[2] & ~r_op[0];

  // op1 is signed for MULH, MULHSU, DIV, REM; op2 for MULH, DIV, REM.
  assign w_s1 = r_a[XLEN-1] &
                ((~r_op[2] & ((r_op[1:0] == 2'b01) | (r_op[1:0] == 2'b10))) | w_div_signed);
  assign w_s2 = r_b[XLEN-1] &
                ((~r_op[2] & (r_op[1:0] == 2'b01)) | w_div_signed);

  // Remainder takes the dividend sign (truncating division); everything else s1^s2.
  assign w_res_neg = w_is_rem ? w_s1 : (w_s1 ^ w_s2);

  // Negating INT_MIN yields INT_MIN, which is the right unsigned magnitude.
  assign w_abs_a = w_s1 ? -r_a : r_a;
  assign w_abs_b = w_s2 ? -r_b : r_b;

  assign w_div_zero = (r_b == '0);
  assign w_div_ovf  = w_div_signed & (r_a == c_INT_MIN) & (r_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
  logic [c_CNT_W-1:0] w_len;   // bit length of |dividend|

  always_comb begin
    w_len = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (w_abs_a[i]) w_len = c_CNT_W'(i + 1);
    end
  end

  // A dividend smaller than the divisor (including zero) needs no iteration.
  assign w_small    = (w_abs_a < w_abs_b);
  assign w_div_iter = w_len;
  // Left-justify the dividend so only its significant bits are iterated.
  assign w_dividend = w_abs_a << (c_DIV_ITER - w_len);
`else
  assign w_small    = 1'b0;
  assign w_div_iter = c_DIV_ITER;
  assign w_dividend = w_abs_a;
`endif

  assign w_special = w_div_zero | w_div_ovf | w_small;

  // Results that never enter the divider loop. The remainder of a short cut
  // is always op1 itself, except for overflow where it is 0.
  always_comb begin
    w_spec_res = '0;
    if (w_div_zero) begin
      w_spec_res = w_is_rem ? r_a : '1;
    end else if (w_div_ovf) begin
      w_spec_res = w_is_rem ? '0 : r_a;
    end else begin
      w_spec_res = w_is_rem ? r_a : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [MUL_STEP-1:0] w_digit;
  logic [2*XLEN-1:0]   w_pp;
  logic [XLEN:0]       w_shift;
  logic                w_ge;
  logic [XLEN-1:0]     w_diff;

  assign w_digit = r_mplier[MUL_STEP-1:0];
  assign w_pp    = r_mcand * {{(2*XLEN-MUL_STEP){1'b0}}, w_digit};

  // The partial remainder is below the divisor, so after the shift it fits in
  // XLEN+1 bits and the successful difference fits back into XLEN bits.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvsr});
  assign w_diff  = w_shift[XLEN-1:0] - r_dvsr;

  // ---------------------------------------------------------------------------
  // Sign correction and result selection
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo_f;
  logic [XLEN-1:0]   w_rem_f;
  logic [XLEN-1:0]   w_fix_res;

  // Full-width negate so MULH* high halves carry the borrow from the low half.
  assign w_prod  = r_neg ? -r_acc : r_acc;
  assign w_quo_f = r_neg ? -r_quo : r_quo;
  assign w_rem_f = r_neg ? -r_rem : r_rem;

  always_comb begin
    w_fix_res = '0;
    if (r_special) begin
      w_fix_res = r_spec_res;
    end else if (!r_op[2]) begin
      w_fix_res = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end else begin
      w_fix_res = r_op[1] ? w_rem_f : w_quo_f;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_neg        <= 1'b0;
      r_special    <= 1'b0;
      r_spec_res   <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_dvsr       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
    end else if (i_flush && (r_state != S_IDLE)) begin
      // Kill wins over hold; any pending result is dropped.
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (i_req_valid && o_req_ready) begin
        r_op    <= i_req_op;
        r_a     <= i_req_op1;
        r_b     <= i_req_op2;
        r_state <= S_PREP;
      end
    end else if (!i_hold) begin
      case (r_state)
        S_PREP: begin
          r_neg     <= w_res_neg;
          r_special <= 1'b0;
          if (!r_op[2]) begin
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_cnt    <= c_MUL_ITER;
            r_state  <= S_MUL;
          end else if (w_special) begin
            r_special  <= 1'b1;
            r_spec_res <= w_spec_res;
            r_state    <= S_FIXUP;
          end else begin
            r_rem   <= '0;
            r_quo   <= w_dividend;
            r_dvsr  <= w_abs_b;
            r_cnt   <= w_div_iter;
            r_state <= S_DIV;
          end
        end

        S_MUL: begin
          r_acc    <= r_acc + w_pp;
          r_mcand  <= r_mcand << MUL_STEP;
          r_mplier <= r_mplier >> MUL_STEP;
          r_cnt    <= r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) r_state <= S_FIXUP;
        end

        S_DIV: begin
          r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_cnt <= r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) r_state <= S_FIXUP;
        end

        S_FIXUP: begin
          r_rsp_result <= w_fix_res;
          r_rsp_valid  <= 1'b1;
          r_state      <= S_DONE;
        end

        S_DONE: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_req_ready  = (r_state == S_IDLE) & ~i_flush;
  assign o_busy       = (r_state != S_IDLE);
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ex_muldiv_iter                                            |
// | Description : Self-checking bench for ex_muldiv_iter (XLEN=32, STEP=4).    |
// |               Directed vectors, handshake/flush/hold/reset scenarios and  |
// |               randomised operations against an arithmetic reference.      |
// |               Honours MULDIV_EARLY_OUT_EN for the expected latencies.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ex_muldiv_iter;

  localparam int XLEN     = 32;
  localparam int MUL_STEP = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_op = 3'd0;
  logic [XLEN-1:0] req_op1 = '0;
  logic [XLEN-1:0] req_op2 = '0;
  logic            flush = 1'b0;
  logic            hold = 1'b0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [XLEN-1:0] rsp_result;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_muldiv_iter #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_op     (req_op),
    .i_req_op1    (req_op1),
    .i_req_op2    (req_op2),
    .i_flush      (flush),
    .i_hold       (hold),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_busy       (busy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result straight from the ISA definition using 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a;            p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a;         p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // Expected accept-to-response latency in cycles.
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic [31:0] ma, mb;
    if (!op[2]) return 2 + XLEN / MUL_STEP;
    if (b == 0) return 2;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
    ma = (!op[0] && a[31]) ? -a : a;
    mb = (!op[0] && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_OUT_EN
    if (ma < mb) return 2;
    return 2 + $clog2({32'b0, ma} + 64'd1);
`else
    if (ma == mb + 32'd1) return 2 + XLEN;  // keeps ma/mb referenced in this build
    return 2 + XLEN;
`endif
  endfunction

  // One full transaction: start at #1 after an edge with the unit idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input string tag,
                        input int rdy_delay, input int hold_at);
    int n;
    check($sformatf("%s/req_ready", tag), {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_op1   = a;
    req_op2   = b;
    rsp_ready = (rdy_delay == 0);
    @(posedge clk); #1;
    // Scramble the request bus; the latched operands must not follow it.
    req_valid = 1'b0;
    req_op    = 3'($urandom_range(0, 7));
    req_op1   = $urandom;
    req_op2   = $urandom;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (hold_at > 0 && n == hold_at)     hold = 1'b1;
      if (hold_at > 0 && n == hold_at + 3) hold = 1'b0;
    end
    check($sformatf("%s/latency", tag), n, exp_lat);
    check($sformatf("%s/result", tag), rsp_result, exp_res);
    if (rdy_delay > 0) begin
      repeat (rdy_delay) begin
        @(posedge clk); #1;
        check($sformatf("%s/held_valid", tag), {31'b0, rsp_valid}, 32'd1);
        check($sformatf("%s/held_result", tag), rsp_result, exp_res);
        check($sformatf("%s/held_req_ready", tag), {31'b0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check($sformatf("%s/valid_drop", tag), {31'b0, rsp_valid}, 32'd0);
    check($sformatf("%s/ready_back", tag), {31'b0, req_ready}, 32'd1);
  endtask

  initial begin : stim
    logic [2:0]  op;
    logic [31:0] a, b;
    int          sel;
    int          seen;

    // Reset state
    #3;
    check("reset/req_ready",  {31'b0, req_ready}, 32'd1);
    check("reset/rsp_valid",  {31'b0, rsp_valid}, 32'd0);
    check("reset/rsp_result", rsp_result, 32'd0);
    check("reset/busy",       {31'b0, busy}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic vectors
    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 10, "mul",    0, 0);
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 10, "mulh",   0, 0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 10, "mulhu",  0, 0);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 10, "mulhsu", 0, 0);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, ref_latency(3'd4, 32'hFFFFFFF9, 32'd2), "div_neg", 0, 0);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, ref_latency(3'd6, 32'hFFFFFFF9, 32'd2), "rem_neg", 0, 0);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, ref_latency(3'd5, 32'd100, 32'd7), "divu", 0, 0);
    run_op(3'd7, 32'd100, 32'd7, 32'd2,  ref_latency(3'd7, 32'd100, 32'd7), "remu", 0, 0);
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 2, "div_by0",  0, 0);
    run_op(3'd7, 32'd5, 32'd0, 32'd5,        2, "remu_by0", 0, 0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, "div_ovf", 0, 0);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2, "rem_ovf", 0, 0);
`ifdef MULDIV_EARLY_OUT_EN
    run_op(3'd5, 32'd3,    32'd5, 32'd0,    2,  "eo_small", 0, 0);
    run_op(3'd5, 32'hFF,   32'd1, 32'hFF,   10, "eo_ff",    0, 0);
`endif

    // Response back-pressure: result and req_ready must hold for 5 cycles
    run_op(3'd5, 32'd100, 32'd7, 32'd14, ref_latency(3'd5, 32'd100, 32'd7), "backpress", 5, 0);

    // Hold for 3 cycles in the middle of a multiply adds 3 cycles of latency
    run_op(3'd0, 32'h12345678, 32'h9ABCDEF0, ref_result(3'd0, 32'h12345678, 32'h9ABCDEF0),
           13, "hold_mul", 0, 3);

    // Reset in the middle of a divide
    req_valid = 1'b1; req_op = 3'd4; req_op1 = 32'h12345678; req_op2 = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("rst_mid/busy_before", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid/busy",       {31'b0, busy}, 32'd0);
    check("rst_mid/rsp_valid",  {31'b0, rsp_valid}, 32'd0);
    check("rst_mid/rsp_result", rsp_result, 32'd0);
    check("rst_mid/req_ready",  {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Flush after 10 divide iterations, with a request competing with the flush
    req_valid = 1'b1; req_op = 3'd5; req_op1 = 32'hFFFFFFFF; req_op2 = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    check("flush/busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    req_valid = 1'b1; req_op = 3'd0; req_op1 = 32'd3; req_op2 = 32'd4;
    check("flush/req_ready_busy", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("flush/busy_after",  {31'b0, busy}, 32'd0);
    check("flush/rsp_valid",   {31'b0, rsp_valid}, 32'd0);
    check("flush/req_ready_idle", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("flush/no_accept", {31'b0, busy}, 32'd0);
    flush = 1'b0;
    req_valid = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen++;
    end
    check("flush/no_rsp", seen, 32'd0);

    // Randomised operations against the reference
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 7);
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(0, 100); b = $urandom_range(1, 300); end
        3: a = a >> $urandom_range(0, 31);
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(op, a, b, ref_result(op, a, b), ref_latency(op, a, b),
             $sformatf("rnd%0d_op%0d", k, op), $urandom_range(0, 2), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
